// File: rtl/mii_frame_monitor_if.sv
// Stream-side bundle for the MII frame monitor: word qualifier, byte lanes
// and per-lane control flags. The master drives the stream; the monitor
// only observes it through the slave modport.
interface mii_frame_monitor_if #(
    parameter int DATA_WIDTH = 64
) ();
    localparam int CTRL_WIDTH = DATA_WIDTH / 8;

    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_tx_data;
    logic [CTRL_WIDTH-1:0] i_tx_ctrl;

    modport master (
        output i_valid,
        output i_tx_data,
        output i_tx_ctrl
    );

    modport slave (
        input i_valid,
        input i_tx_data,
        input i_tx_ctrl
    );
endinterface

// File: rtl/mii_frame_monitor.sv
// Passive XGMII-style frame monitor for DATA_WIDTH/8 byte lanes.
// Delimits frames on START (lane 0 only) and TERM (any lane). For each
// closed frame it reports the byte length, and for each closed gap the
// idle byte count, flagging out-of-range values and control-character
// violations. Saturating frame/error counters are cleared by i_clear.
// Optional build macro MII_MON_STATS_EN adds min/max good-frame length.
module mii_frame_monitor #(
    parameter int         DATA_WIDTH      = 64,
    parameter int         CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter logic [7:0] IDLE_CODE       = 8'h07,
    parameter logic [7:0] START_CODE      = 8'hFB,
    parameter logic [7:0] TERM_CODE       = 8'hFD,
    parameter int         MIN_FRAME_BYTES = 64,
    parameter int         MAX_FRAME_BYTES = 1518,
    parameter int         MIN_IPG_BYTES   = 12,
    parameter int         MAX_IPG_BYTES   = 0,
    parameter int         LEN_WIDTH       = 16,
    parameter int         CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    mii_frame_monitor_if.slave   mii,
    input  logic                 i_clear,
    output logic                 o_in_frame,
    output logic                 o_frame_done,
    output logic [LEN_WIDTH-1:0] o_frame_len,
    output logic                 o_len_error,
    output logic                 o_ipg_done,
    output logic [LEN_WIDTH-1:0] o_ipg_len,
    output logic                 o_ipg_error,
    output logic                 o_ctrl_error,
    output logic [CNT_WIDTH-1:0] o_frame_cnt,
    output logic [CNT_WIDTH-1:0] o_err_cnt
`ifdef MII_MON_STATS_EN
    ,
    output logic [LEN_WIDTH-1:0] o_min_len,
    output logic [LEN_WIDTH-1:0] o_max_len
`endif
);

    localparam int IDX_W = (CTRL_WIDTH > 1) ? $clog2(CTRL_WIDTH) : 1;

    localparam logic [LEN_WIDTH-1:0] LEN_ONES  = '1;
    localparam logic [LEN_WIDTH-1:0] START_LEN = LEN_WIDTH'(CTRL_WIDTH - 1);
    localparam logic [LEN_WIDTH:0]   LANES_EXT = (LEN_WIDTH + 1)'(CTRL_WIDTH);
    localparam logic [LEN_WIDTH-1:0] MIN_LEN   = LEN_WIDTH'(MIN_FRAME_BYTES);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_FRAME_BYTES);
    localparam logic [LEN_WIDTH-1:0] MIN_GAP   = LEN_WIDTH'(MIN_IPG_BYTES);
    localparam logic [LEN_WIDTH-1:0] MAX_GAP   = LEN_WIDTH'(MAX_IPG_BYTES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONES  = '1;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        IN_FRAME   = 2'd1,
        IN_GAP     = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 len_sat_q, len_sat_d;
    logic [LEN_WIDTH-1:0] gap_q, gap_d;
    logic                 gap_sat_q, gap_sat_d;

    logic                 in_frame_q;
    logic                 frame_done_q, frame_done_d;
    logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
    logic                 len_error_q, len_error_d;
    logic                 ipg_done_q, ipg_done_d;
    logic [LEN_WIDTH-1:0] ipg_len_q, ipg_len_d;
    logic                 ipg_error_q, ipg_error_d;
    logic                 ctrl_error_q, ctrl_error_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // ------------------------------------------------------------------
    // Per-lane character decode
    // ------------------------------------------------------------------
    logic [CTRL_WIDTH-1:0] lane_idle;
    logic [CTRL_WIDTH-1:0] lane_term;
    logic [CTRL_WIDTH-1:0] lane_start;
    logic [CTRL_WIDTH-1:0] tail_idle;

    for (genvar gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
        logic [7:0] lane_byte;
        assign lane_byte      = mii.i_tx_data[8*gi +: 8];
        assign lane_idle[gi]  = mii.i_tx_ctrl[gi] && (lane_byte == IDLE_CODE);
        assign lane_term[gi]  = mii.i_tx_ctrl[gi] && (lane_byte == TERM_CODE);
        assign lane_start[gi] = mii.i_tx_ctrl[gi] && (lane_byte == START_CODE);
    end

    // tail_idle[k]: every lane above k carries a control IDLE
    always_comb begin : p_tail_idle
        logic run;
        run = 1'b1;
        for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
            tail_idle[i] = run;
            run          = run & lane_idle[i];
        end
    end

    // Lowest lane with its control flag set
    logic             first_found;
    logic [IDX_W-1:0] first_idx;

    // Priority scan: the loop runs downward so the lowest hit wins
    always_comb begin : p_first_ctrl
        first_found = 1'b0;
        first_idx   = '0;
        for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
            if (mii.i_tx_ctrl[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
        end
    end

    logic start_misplaced;
    logic other_ctrl;
    logic all_idle;
    logic first_is_term;
    logic first_tail_ok;

    assign start_misplaced = |lane_start[CTRL_WIDTH-1:1];
    assign other_ctrl      = |mii.i_tx_ctrl[CTRL_WIDTH-1:1];
    assign all_idle        = &lane_idle;
    assign first_is_term   = lane_term[first_idx];
    assign first_tail_ok   = tail_idle[first_idx];

    // ------------------------------------------------------------------
    // Saturating accumulators. The extra top bit is the carry that marks
    // saturation; once saturated, the flag sticks until the next restart.
    // ------------------------------------------------------------------
    logic [LEN_WIDTH:0]   len_addend;
    logic [LEN_WIDTH:0]   len_sum_full;
    logic [LEN_WIDTH-1:0] len_sum;
    logic                 len_sum_sat;
    logic [LEN_WIDTH:0]   gap_sum_full;
    logic [LEN_WIDTH-1:0] gap_sum;
    logic                 gap_sum_sat;
    logic [LEN_WIDTH-1:0] gap_after_term;
    logic                 len_bad;
    logic                 gap_bad;

    assign len_addend     = first_found ? (LEN_WIDTH + 1)'(first_idx) : LANES_EXT;
    assign len_sum_full   = {1'b0, len_q} + len_addend;
    assign len_sum        = len_sum_full[LEN_WIDTH] ? LEN_ONES : len_sum_full[LEN_WIDTH-1:0];
    assign len_sum_sat    = len_sat_q | len_sum_full[LEN_WIDTH];
    assign gap_sum_full   = {1'b0, gap_q} + LANES_EXT;
    assign gap_sum        = gap_sum_full[LEN_WIDTH] ? LEN_ONES : gap_sum_full[LEN_WIDTH-1:0];
    assign gap_sum_sat    = gap_sat_q | gap_sum_full[LEN_WIDTH];
    assign gap_after_term = START_LEN - LEN_WIDTH'(first_idx);

    assign len_bad = len_sum_sat || (len_sum < MIN_LEN) || (len_sum > MAX_LEN);
    assign gap_bad = gap_sat_q || (gap_q < MIN_GAP) ||
                     ((MAX_IPG_BYTES != 0) && (gap_q > MAX_GAP));

    // Frame/gap state machine: next state, accumulators and result pulses
    always_comb begin : p_next
        state_d      = state_q;
        len_d        = len_q;
        len_sat_d    = len_sat_q;
        gap_d        = gap_q;
        gap_sat_d    = gap_sat_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        len_error_d  = 1'b0;
        ipg_done_d   = 1'b0;
        ipg_len_d    = ipg_len_q;
        ipg_error_d  = 1'b0;
        ctrl_error_d = 1'b0;

        if (mii.i_valid) begin
            case (state_q)
                WAIT_START: begin
                    if (start_misplaced) begin
                        ctrl_error_d = 1'b1;
                    end else if (lane_start[0]) begin
                        state_d   = IN_FRAME;
                        len_d     = START_LEN;
                        len_sat_d = 1'b0;
                    end
                end

                IN_FRAME: begin
                    if (start_misplaced) begin
                        ctrl_error_d = 1'b1;
                        state_d      = WAIT_START;
                    end else if (!first_found) begin
                        len_d     = len_sum;
                        len_sat_d = len_sum_sat;
                    end else if (first_is_term) begin
                        // The frame closes even if the tail after TERM is dirty
                        frame_done_d = 1'b1;
                        frame_len_d  = len_sum;
                        len_error_d  = len_bad;
                        ctrl_error_d = !first_tail_ok;
                        len_d        = len_sum;
                        len_sat_d    = len_sum_sat;
                        gap_d        = gap_after_term;
                        gap_sat_d    = 1'b0;
                        state_d      = IN_GAP;
                    end else begin
                        ctrl_error_d = 1'b1;
                        state_d      = WAIT_START;
                    end
                end

                IN_GAP: begin
                    if (start_misplaced) begin
                        ctrl_error_d = 1'b1;
                        state_d      = WAIT_START;
                    end else if (all_idle) begin
                        gap_d     = gap_sum;
                        gap_sat_d = gap_sum_sat;
                    end else if (lane_start[0] && !other_ctrl) begin
                        ipg_done_d  = 1'b1;
                        ipg_len_d   = gap_q;
                        ipg_error_d = gap_bad;
                        len_d       = START_LEN;
                        len_sat_d   = 1'b0;
                        state_d     = IN_FRAME;
                    end else begin
                        ctrl_error_d = 1'b1;
                        state_d      = WAIT_START;
                    end
                end

                default: begin
                    state_d = WAIT_START;
                end
            endcase
        end
    end

    // Statistics counters: clear wins over this cycle's increments
    always_comb begin : p_counters
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (i_clear) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
        end else begin
            if (frame_done_d && (frame_cnt_q != CNT_ONES)) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if ((len_error_d || ipg_error_d || ctrl_error_d) && (err_cnt_q != CNT_ONES)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    // State, accumulators and all registered outputs
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= WAIT_START;
            len_q        <= '0;
            len_sat_q    <= 1'b0;
            gap_q        <= '0;
            gap_sat_q    <= 1'b0;
            in_frame_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            len_error_q  <= 1'b0;
            ipg_done_q   <= 1'b0;
            ipg_len_q    <= '0;
            ipg_error_q  <= 1'b0;
            ctrl_error_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            len_sat_q    <= len_sat_d;
            gap_q        <= gap_d;
            gap_sat_q    <= gap_sat_d;
            in_frame_q   <= (state_d == IN_FRAME);
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            len_error_q  <= len_error_d;
            ipg_done_q   <= ipg_done_d;
            ipg_len_q    <= ipg_len_d;
            ipg_error_q  <= ipg_error_d;
            ctrl_error_q <= ctrl_error_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_in_frame   = in_frame_q;
    assign o_frame_done = frame_done_q;
    assign o_frame_len  = frame_len_q;
    assign o_len_error  = len_error_q;
    assign o_ipg_done   = ipg_done_q;
    assign o_ipg_len    = ipg_len_q;
    assign o_ipg_error  = ipg_error_q;
    assign o_ctrl_error = ctrl_error_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_err_cnt    = err_cnt_q;

`ifdef MII_MON_STATS_EN
    logic [LEN_WIDTH-1:0] min_len_q, min_len_d;
    logic [LEN_WIDTH-1:0] max_len_q, max_len_d;

    // Min/max tracking over frames closed by TERM with a legal length
    always_comb begin : p_stats
        min_len_d = min_len_q;
        max_len_d = max_len_q;
        if (i_clear) begin
            min_len_d = LEN_ONES;
            max_len_d = '0;
        end else if (frame_done_d && !len_error_d) begin
            if (frame_len_d < min_len_q) begin
                min_len_d = frame_len_d;
            end
            if (frame_len_d > max_len_q) begin
                max_len_d = frame_len_d;
            end
        end
    end

    // Stats registers; min starts at all-ones so the first good frame wins
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            min_len_q <= LEN_ONES;
            max_len_q <= '0;
        end else begin
            min_len_q <= min_len_d;
            max_len_q <= max_len_d;
        end
    end

    assign o_min_len = min_len_q;
    assign o_max_len = max_len_q;
`endif

endmodule

// File: tb/tb_mii_frame_monitor.sv
// Testbench for mii_frame_monitor (DATA_WIDTH=64). Frames are described as
// byte/character streams (START, payload, TERM, idles); the expected frame
// lengths and gaps are byte counts taken from that description and checked
// against the monitor's pulses, held results and counters every cycle.
`timescale 1ns/1ps
module tb_mii_frame_monitor;
    localparam int DW   = 64;
    localparam int LN   = 8;
    localparam int LW   = 16;
    localparam int CW   = 32;
    localparam int MAXW = 4096;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;

    mii_frame_monitor_if #(.DATA_WIDTH(DW)) mii_bus ();

    logic          in_frame, frame_done, len_error, ipg_done, ipg_error, ctrl_error;
    logic [LW-1:0] frame_len, ipg_len;
    logic [CW-1:0] frame_cnt, err_cnt;
`ifdef MII_MON_STATS_EN
    logic [LW-1:0] min_len, max_len;
`endif

    mii_frame_monitor #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .mii          (mii_bus),
        .i_clear      (clear),
        .o_in_frame   (in_frame),
        .o_frame_done (frame_done),
        .o_frame_len  (frame_len),
        .o_len_error  (len_error),
        .o_ipg_done   (ipg_done),
        .o_ipg_len    (ipg_len),
        .o_ipg_error  (ipg_error),
        .o_ctrl_error (ctrl_error),
        .o_frame_cnt  (frame_cnt),
        .o_err_cnt    (err_cnt)
`ifdef MII_MON_STATS_EN
        ,
        .o_min_len    (min_len),
        .o_max_len    (max_len)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cur_w = 0;

    // Character stream: bit 8 = control flag, bits 7:0 = byte
    logic [8:0] chq[$];
    bit ev_done[MAXW], ev_lerr[MAXW], ev_ipg[MAXW], ev_gerr[MAXW], ev_ctrl[MAXW];
    bit ev_start[MAXW], ev_stop[MAXW], w_clr[MAXW], w_slow[MAXW];
    int ev_len[MAXW], ev_glen[MAXW];

    // Stream-builder bookkeeping
    bit gap_valid = 0;
    int gap_count = 0;
    int pay_count = 0;
    int last_start_w = 0;
    int last_term_w  = 0;

    // Reference model state
    bit m_inf = 0;
    int m_flen = 0, m_glen = 0, m_frames = 0, m_errs = 0;
    int m_min = 16'hFFFF, m_max = 0;
    bit e_done = 0, e_lerr = 0, e_ipg = 0, e_gerr = 0, e_ctrl = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s word=%0d observed=%0d expected=%0d", tag, cur_w, obs, exp);
        end
    endtask

    task automatic clear_stream();
        chq.delete();
        for (int i = 0; i < MAXW; i++) begin
            ev_done[i] = 0; ev_lerr[i] = 0; ev_ipg[i] = 0; ev_gerr[i] = 0; ev_ctrl[i] = 0;
            ev_start[i] = 0; ev_stop[i] = 0; w_clr[i] = 0; w_slow[i] = 0;
            ev_len[i] = 0; ev_glen[i] = 0;
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) chq.push_back({1'b1, 8'h07});
        if (gap_valid) gap_count += n;
    endtask

    task automatic push_start();
        int w;
        while (chq.size() % LN != 0) push_idle(1);
        w = chq.size() / LN;
        ev_start[w] = 1;
        if (gap_valid) begin
            ev_ipg[w]  = 1;
            ev_glen[w] = gap_count;
            ev_gerr[w] = (gap_count < 12);
        end
        chq.push_back({1'b1, 8'hFB});
        gap_valid    = 0;
        pay_count    = 0;
        last_start_w = w;
    endtask

    task automatic push_data(input int n);
        for (int i = 0; i < n; i++) chq.push_back({1'b0, 8'($urandom_range(0, 255))});
        pay_count += n;
    endtask

    task automatic push_term();
        int w;
        w = chq.size() / LN;
        ev_done[w] = 1;
        ev_len[w]  = pay_count;
        ev_lerr[w] = (pay_count < 64) || (pay_count > 1518);
        ev_stop[w] = 1;
        chq.push_back({1'b1, 8'hFD});
        gap_valid   = 1;
        gap_count   = 0;
        last_term_w = w;
    endtask

    task automatic push_bad(input logic [7:0] code);
        int w;
        w = chq.size() / LN;
        ev_ctrl[w] = 1;
        ev_stop[w] = 1;
        chq.push_back({1'b1, code});
        gap_valid = 0;
    endtask

    task automatic frame(input int n);
        push_start();
        push_data(n);
        push_term();
    endtask

    // Advance the reference model by one sampled cycle
    task automatic model_step(input bit v, input int w, input bit clr);
        e_done = v && ev_done[w];
        e_lerr = e_done && ev_lerr[w];
        e_ipg  = v && ev_ipg[w];
        e_gerr = e_ipg && ev_gerr[w];
        e_ctrl = v && ev_ctrl[w];
        if (v && ev_start[w]) m_inf = 1;
        if (v && ev_stop[w])  m_inf = 0;
        if (e_done) begin
            m_flen = ev_len[w];
            $display("frame closed word=%0d len=%0d len_err=%0b", w, ev_len[w], ev_lerr[w]);
        end
        if (e_ipg) m_glen = ev_glen[w];
        if (clr) begin
            m_frames = 0;
            m_errs   = 0;
            m_min    = 16'hFFFF;
            m_max    = 0;
        end else begin
            m_frames += int'(e_done);
            m_errs   += int'(e_lerr || e_gerr || e_ctrl);
            if (e_done && !e_lerr) begin
                if (ev_len[w] < m_min) m_min = ev_len[w];
                if (ev_len[w] > m_max) m_max = ev_len[w];
            end
        end
    endtask

    task automatic check_all();
        chk("in_frame",   64'(in_frame),   64'(m_inf));
        chk("frame_done", 64'(frame_done), 64'(e_done));
        chk("len_error",  64'(len_error),  64'(e_lerr));
        chk("ipg_done",   64'(ipg_done),   64'(e_ipg));
        chk("ipg_error",  64'(ipg_error),  64'(e_gerr));
        chk("ctrl_error", 64'(ctrl_error), 64'(e_ctrl));
        chk("frame_len",  64'(frame_len),  64'(m_flen));
        chk("ipg_len",    64'(ipg_len),    64'(m_glen));
        chk("frame_cnt",  64'(frame_cnt),  64'(m_frames));
        chk("err_cnt",    64'(err_cnt),    64'(m_errs));
`ifdef MII_MON_STATS_EN
        chk("min_len",    64'(min_len),    64'(m_min));
        chk("max_len",    64'(max_len),    64'(m_max));
`endif
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [LN-1:0] c, input logic clr);
        mii_bus.i_valid   = v;
        mii_bus.i_tx_data = d;
        mii_bus.i_tx_ctrl = c;
        clear             = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream();
        int nw;
        logic [DW-1:0] d;
        logic [LN-1:0] c;
        while (chq.size() % LN != 0) push_idle(1);
        nw = chq.size() / LN;
        for (int w = 0; w < nw; w++) begin
            cur_w = w;
            if (w_slow[w] || ($urandom_range(0, 7) == 0)) begin
                drive(1'b0, {$urandom, $urandom}, LN'($urandom), 1'b0);
                model_step(1'b0, w, 1'b0);
                check_all();
            end
            for (int l = 0; l < LN; l++) begin
                d[8*l +: 8] = chq[w*LN + l][7:0];
                c[l]        = chq[w*LN + l][8];
            end
            drive(1'b1, d, c, w_clr[w]);
            model_step(1'b1, w, w_clr[w]);
            check_all();
        end
        mii_bus.i_valid = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic model_reset();
        m_inf = 0; m_flen = 0; m_glen = 0; m_frames = 0; m_errs = 0;
        m_min = 16'hFFFF; m_max = 0;
        e_done = 0; e_lerr = 0; e_ipg = 0; e_gerr = 0; e_ctrl = 0;
        gap_valid = 0; gap_count = 0; pay_count = 0;
    endtask

    initial begin
        int lens[7];
        logic [7:0] bad_codes[4];
        rst_n             = 1'b0;
        clear             = 1'b0;
        mii_bus.i_valid   = 1'b0;
        mii_bus.i_tx_data = '0;
        mii_bus.i_tx_ctrl = '0;
        lens      = '{8, 63, 64, 65, 1518, 1519, 200};
        bad_codes = '{8'hFE, 8'hFB, 8'h07, 8'h9C};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cur_w = -1;
        check_all();
        rst_n = 1'b1;

        // Directed frames: 64 (TERM lane 1), 63, gap cases, TERM lane 7
        clear_stream();
        frame(64);  push_idle(8);
        frame(63);  push_idle(8);
        frame(64);  push_idle(8);
        frame(70);  push_idle(8);     // TERM lands in lane 7
        frame(64);  push_idle(8);     // gap of 8 -> ipg error
        // Bad control character in lane 3 mid-frame, then unchecked restart
        push_start(); push_data(10); push_bad(8'hFE); push_idle(5);
        frame(64);  push_idle(8);
        // 1600-byte frame with valid toggling, clear around the TERM report
        frame(1600); push_idle(8);
        for (int w = last_start_w; w <= last_term_w + 1; w++) w_slow[w] = 1;
        w_clr[last_term_w]     = 1;
        w_clr[last_term_w + 1] = 1;
        // Randomised frames, gaps and aborts
        for (int i = 0; i < 10; i++) begin
            push_idle($urandom_range(0, 20));
            if ($urandom_range(0, 4) == 0) begin
                push_start();
                push_data($urandom_range(8, 40));
                push_bad(bad_codes[$urandom_range(0, 3)]);
            end else begin
                frame(($urandom_range(0, 2) == 0) ? $urandom_range(8, 400)
                                                  : lens[$urandom_range(0, 6)]);
            end
        end
        push_idle(8);
        send_stream();

        // Reset in the middle of a frame: partial frame is forgotten
        clear_stream();
        push_start(); push_data(47);
        send_stream();
        rst_n = 1'b0;
        #2;
        model_reset();
        cur_w = -2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // After reset: first frame has no gap check; stats over 64/1000/300
        clear_stream();
        push_idle(5);
        frame(64);   push_idle(9);
        frame(1000); push_idle(12);
        frame(300);  push_idle(8);
        send_stream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit reached");
    end
endmodule

// File: doc/mii_frame_monitor.md
Name: mii_frame_monitor

Overview:
Parametrised successor to the existing 64-bit MII frame checker, for any lane count (DATA_WIDTH/8 byte lanes). It passively monitors an XGMII-style data/control stream and delimits frames on START and TERM codes. For each frame it reports byte length, inter-packet gap and control-character violations. Per-frame result pulses and saturating statistics counters feed the testbench scoreboard and the link-status register block.

Parameters:
DATA_WIDTH, 64, stream width in bits; multiple of 8, 16..512
CTRL_WIDTH, DATA_WIDTH/8, one control bit per byte lane
IDLE_CODE, 8'h07, idle control character
START_CODE, 8'hFB, start control character, legal in lane 0 only
TERM_CODE, 8'hFD, terminate control character, legal in any lane
MIN_FRAME_BYTES, 64, minimum legal length (bytes strictly between START and TERM)
MAX_FRAME_BYTES, 1518, maximum legal length
MIN_IPG_BYTES, 12, minimum gap in bytes (TERM excluded, START excluded)
MAX_IPG_BYTES, 0, maximum gap; 0 disables the check
LEN_WIDTH, 16, width of the length/gap result fields
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  word qualifier; low = word ignored, all state held
i_tx_data  in  DATA_WIDTH  byte lanes, lane k = bits [8k+7:8k]
i_tx_ctrl  in  CTRL_WIDTH  per-lane control flag
i_clear  in  1  synchronous clear of statistics counters
o_in_frame  out  1  high while between accepted START and TERM/abort
o_frame_done  out  1  one-cycle pulse: frame closed by TERM
o_frame_len  out  LEN_WIDTH  length of last closed frame, saturating
o_len_error  out  1  pulse with o_frame_done if length outside [MIN,MAX]
o_ipg_done  out  1  one-cycle pulse: gap closed by START
o_ipg_len  out  LEN_WIDTH  gap length of last closed gap, saturating
o_ipg_error  out  1  pulse with o_ipg_done if gap out of range
o_ctrl_error  out  1  one-cycle pulse: control-character violation
o_frame_cnt  out  CNT_WIDTH  frames closed by TERM
o_err_cnt  out  CNT_WIDTH  cycles with any of len/ipg/ctrl error pulses

Behaviour:
- Reset: state WAIT_START; all outputs, counters and length accumulators 0.
- All outputs registered; pulses assert the cycle after the qualifying word is sampled.
- States: WAIT_START, IN_FRAME, IN_GAP.
- WAIT_START: lane0 ctrl=1 and START_CODE -> IN_FRAME, len = CTRL_WIDTH-1. No gap check on the first frame after reset or abort. Any other word stays here silently.
- IN_FRAME: scan lanes from 0 for the lowest lane k with ctrl=1.
  - No ctrl lane: len += CTRL_WIDTH.
  - Lane k is TERM: len += k -> IN_GAP; gap = CTRL_WIDTH-1-k. Pulse o_frame_done, update o_frame_len and check length.
  - Lane k is TERM but any lane >k is not ctrl=1 IDLE: still close the frame, plus o_ctrl_error.
  - Lane k is a non-TERM control character: o_ctrl_error, abort with no o_frame_done -> WAIT_START.
- IN_GAP:
  - All lanes ctrl=1 IDLE: gap += CTRL_WIDTH.
  - Lane0 START (ctrl=1) with no other ctrl lane violating: pulse o_ipg_done, check against MIN (and MAX if nonzero) -> IN_FRAME, len = CTRL_WIDTH-1.
  - Anything else: o_ctrl_error, gap discarded -> WAIT_START.
- START in any lane other than 0, in any state: o_ctrl_error. IN_FRAME aborts; other states go to WAIT_START.
- Accumulators saturate at 2^LEN_WIDTH-1. Saturation counts as out-of-range.
- Counters saturate at all-ones. i_clear has priority: the cycle's increments are dropped and the counters read 0 next cycle.
- i_valid low: no scan, no accumulation, no pulses; counters still clear on i_clear.
- Reset mid-frame: immediate return to reset state; the partial frame is neither reported nor counted.

Optional Feature:
MII_MON_STATS_EN. When defined, adds outputs o_min_len and o_max_len (LEN_WIDTH each), updated from every frame closed by TERM without len error. Reset and i_clear set o_min_len to all-ones and o_max_len to 0. When undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- DATA_WIDTH=64. START word, 7 data words, TERM in lane 1 with idles after -> o_frame_done, o_frame_len=64, o_len_error=0, o_frame_cnt=1.
- Same frame with TERM in lane 0 -> o_frame_len=63, o_len_error=1, o_err_cnt=1.
- Good frame ending with TERM lane 1, one all-idle word, then START -> o_ipg_done, o_ipg_len=14, o_ipg_error=0. With TERM lane 7 instead -> o_ipg_len=8, o_ipg_error=1.
- Control 8'hFE (ctrl=1) in lane 3 mid-frame -> o_ctrl_error pulse, o_in_frame drops, no o_frame_done; the next START is accepted with no gap check.
- 1600-byte frame, i_valid toggled every other cycle -> o_frame_len=1600, o_len_error=1. Assert i_clear in the TERM-report cycle -> o_frame_cnt=0 and o_err_cnt=0 next cycle.
- With MII_MON_STATS_EN: frames of 64, 1000 and 300 bytes -> o_min_len=64, o_max_len=1000. Reset mid-frame -> all outputs 0, o_min_len all-ones.
